vector_builder: RTL and testbench

//  Inverse of the leading-one position detector: rebuilds a 32-bit vector from a stream of
//  MSB-first bit positions (pos 0 = bit 31, pos 31 = bit 0, pos 32 = "no bit").

---
 rtl/vector_det_pkg.sv | 27 ++
 rtl/vector_pos_decoder.sv | 21 ++
 rtl/vector_builder.sv | 118 +++++++++++
 tb/tb_vector_builder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vector_det_pkg.sv
// Shared definitions for the vector builder.
// Holds the vector/position widths, the null-position code, the FSM state
// encoding and a popcount helper used on the assembled vector.
package vector_det_pkg;

  localparam int DATA_W = 32;
  localparam int POS_W  = $clog2(DATA_W) + 1;

  // Position code meaning "no bit"; any larger code is treated the same way.
  localparam logic [POS_W-1:0] NULL_POS = POS_W'(DATA_W);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Number of ones in a DATA_W vector; DATA_W itself fits in POS_W bits.
  function automatic logic [POS_W-1:0] popcount(input logic [DATA_W-1:0] v);
    logic [POS_W-1:0] c;
    c = {POS_W{1'b0}};
    for (int i = 0; i < DATA_W; i++) begin
      c = c + {{(POS_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/vector_pos_decoder.sv
// Combinational MSB-first position decoder.
// Ports:
//   pos     in  POS_W   bit position, 0 = MSB (bit DATA_W-1)
//   onehot  out DATA_W  one-hot vector, all zero for pos >= DATA_W
module vector_pos_decoder
  import vector_det_pkg::*;
(
  input  logic [POS_W-1:0]  pos,
  output logic [DATA_W-1:0] onehot
);

  // Each bit compares against its own MSB-first position; positions at or
  // beyond DATA_W never match, which gives the null behaviour for free.
  always_comb begin
    onehot = {DATA_W{1'b0}};
    for (int i = 0; i < DATA_W; i++) begin
      onehot[DATA_W-1-i] = (pos == POS_W'(i));
    end
  end

endmodule

// File: rtl/vector_builder.sv
// Rebuilds a DATA_W vector from a stream of MSB-first bit positions.
// Tokens are OR-accumulated until one tagged last; the finished vector and
// its popcount are then offered on the output handshake.
// Optional feature: define VECTOR_BUILDER_DUP_CHECK_EN to get a one-cycle
// err_dup pulse when a token sets a bit that is already set in the frame.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pos_valid/pos_ready   input token handshake
//   pos_in, pos_last      token position and frame-close flag
//   vec_valid/vec_ready   output vector handshake
//   vec_out, vec_cnt      assembled vector and its popcount
//   err_dup               duplicate-position pulse (0 when feature disabled)
module vector_builder
  import vector_det_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pos_valid,
  output logic              pos_ready,
  input  logic [POS_W-1:0]  pos_in,
  input  logic              pos_last,
  output logic              vec_valid,
  input  logic              vec_ready,
  output logic [DATA_W-1:0] vec_out,
  output logic [POS_W-1:0]  vec_cnt,
  output logic              err_dup
);

  state_t            state;
  state_t            next_state;
  logic              run;
  logic              accept;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] onehot;
  logic [DATA_W-1:0] merged;

  vector_pos_decoder u_dec (
    .pos    (pos_in),
    .onehot (onehot)
  );

  assign merged = acc | onehot;

  // State register; run holds pos_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      run   <= 1'b0;
    end else begin
      state <= next_state;
      run   <= 1'b1;
    end
  end

  // Next-state and handshake decode; depends on registered state only for pos_ready.
  always_comb begin
    next_state = state;
    pos_ready  = 1'b0;
    accept     = 1'b0;
    case (state)
      ACCUM: begin
        pos_ready = run;
        accept    = pos_valid & run;
        if (accept && pos_last) begin
          next_state = HOLD;
        end else begin
          next_state = ACCUM;
        end
      end
      HOLD: begin
        // vec_valid is always set while in HOLD, so vec_ready alone completes it.
        if (vec_ready) begin
          next_state = ACCUM;
        end else begin
          next_state = HOLD;
        end
      end
      default: begin
        next_state = ACCUM;
      end
    endcase
  end

  // Accumulator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= {DATA_W{1'b0}};
      vec_out   <= {DATA_W{1'b0}};
      vec_cnt   <= {POS_W{1'b0}};
      vec_valid <= 1'b0;
    end else if (accept) begin
      if (pos_last) begin
        vec_out   <= merged;
        vec_cnt   <= popcount(merged);
        acc       <= {DATA_W{1'b0}};
        vec_valid <= 1'b1;
      end else begin
        acc <= merged;
      end
    end else if ((state == HOLD) && vec_ready) begin
      vec_valid <= 1'b0;
    end
  end

`ifdef VECTOR_BUILDER_DUP_CHECK_EN
  // Duplicate detect: null positions decode to zero and so never flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_dup <= 1'b0;
    end else begin
      err_dup <= accept & (|(acc & onehot));
    end
  end
`else
  assign err_dup = 1'b0;
`endif

endmodule

// File: tb/tb_vector_builder.sv
// Directed testbench for vector_builder with hand-computed expectations.
module tb_vector_builder;
  import vector_det_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              pos_valid;
  logic              pos_ready;
  logic [POS_W-1:0]  pos_in;
  logic              pos_last;
  logic              vec_valid;
  logic              vec_ready;
  logic [DATA_W-1:0] vec_out;
  logic [POS_W-1:0]  vec_cnt;
  logic              err_dup;

  int tests_run;
  int tests_failed;

`ifdef VECTOR_BUILDER_DUP_CHECK_EN
  localparam logic DUP_EXP = 1'b1;
`else
  localparam logic DUP_EXP = 1'b0;
`endif

  vector_builder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pos_valid (pos_valid),
    .pos_ready (pos_ready),
    .pos_in    (pos_in),
    .pos_last  (pos_last),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_out   (vec_out),
    .vec_cnt   (vec_cnt),
    .err_dup   (err_dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one token and return just after the edge that accepts it.
  task automatic send(input int p, input logic last);
    int n;
    @(negedge clk);
    pos_valid = 1'b1;
    pos_in    = POS_W'(p);
    pos_last  = last;
    n = 0;
    while (!pos_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!pos_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    pos_valid = 1'b0;
    pos_last  = 1'b0;
  endtask

  // Complete the output handshake.
  task automatic take_vec();
    int n;
    @(negedge clk);
    vec_ready = 1'b1;
    n = 0;
    while (!vec_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!vec_valid) check("take_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    vec_ready = 1'b0;
  endtask

  task automatic check_vec(input string tag, input logic [31:0] v, input logic [31:0] c);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, vec_valid}, 32'd1);
    check({tag, "_vec"}, vec_out, v);
    check({tag, "_cnt"}, {26'd0, vec_cnt}, c);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    pos_valid    = 1'b0;
    pos_in       = '0;
    pos_last     = 1'b0;
    vec_ready    = 1'b0;

    // 1 reset values
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, vec_valid}, 32'd0);
    check("rst_vec", vec_out, 32'd0);
    check("rst_cnt", {26'd0, vec_cnt}, 32'd0);
    check("rst_ready", {31'd0, pos_ready}, 32'd0);
    check("rst_dup", {31'd0, err_dup}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", {31'd0, pos_ready}, 32'd1);

    // 2 basic frame
    send(0, 1'b0);
    send(5, 1'b0);
    send(31, 1'b1);
    check_vec("f2", 32'h8400_0001, 32'd3);
    check("f2_ready", {31'd0, pos_ready}, 32'd0);
    take_vec();
    @(negedge clk);
    check("f2_done", {31'd0, vec_valid}, 32'd0);

    // 3 null tokens
    send(32, 1'b1);
    check_vec("null32", 32'h0000_0000, 32'd0);
    take_vec();
    send(40, 1'b1);
    check_vec("null40", 32'h0000_0000, 32'd0);
    take_vec();

    // 4 backpressure with a held token
    send(2, 1'b1);
    @(negedge clk);
    pos_valid = 1'b1;
    pos_in    = POS_W'(9);
    pos_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_vec", vec_out, 32'h2000_0000);
      check("bp_valid", {31'd0, vec_valid}, 32'd1);
      check("bp_ready", {31'd0, pos_ready}, 32'd0);
      @(negedge clk);
    end
    vec_ready = 1'b1;
    @(posedge clk);
    #1;
    vec_ready = 1'b0;
    @(negedge clk);
    check("bp_rel_ready", {31'd0, pos_ready}, 32'd1);
    check("bp_rel_valid", {31'd0, vec_valid}, 32'd0);
    check("bp_keep_vec", vec_out, 32'h2000_0000);
    @(posedge clk);
    #1;
    pos_valid = 1'b0;
    pos_last  = 1'b0;
    check_vec("held", 32'h0040_0000, 32'd1);
    take_vec();

    // 5 duplicate position
    send(7, 1'b0);
    @(negedge clk);
    check("dup_first", {31'd0, err_dup}, 32'd0);
    send(7, 1'b1);
    @(negedge clk);
    check("dup_pulse", {31'd0, err_dup}, {31'd0, DUP_EXP});
    check("dup_vec", vec_out, 32'h0100_0000);
    check("dup_cnt", {26'd0, vec_cnt}, 32'd1);
    @(negedge clk);
    check("dup_clear", {31'd0, err_dup}, 32'd0);
    take_vec();

    // 6 reset mid-frame
    send(3, 1'b0);
    send(4, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", {31'd0, pos_ready}, 32'd0);
    check("mid_rst_vec", vec_out, 32'd0);
    rst_n = 1'b1;
    send(10, 1'b1);
    check_vec("mid", 32'h0020_0000, 32'd1);
    take_vec();

    // full vector: popcount of all ones must reach 32
    for (int p = 0; p < 32; p++) begin
      send(p, (p == 31) ? 1'b1 : 1'b0);
    end
    check_vec("full", 32'hFFFF_FFFF, 32'd32);
    take_vec();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
